stream_aux_slave: RTL and testbench

Receive-side counterpart of the auxiliary AXI-Stream test master. Accepts a stream whose payload should be the incrementing sequence 1, 2, 3, ... ending with `tlast` on beat `total_num`. It applies a programmable periodic backpressure pattern, checks every accepted beat's data and `tlast` position, and reports beat and error counts plus a done/pass summary. It sits at the sink end of stream links in interconnect test benches and loopback setups.

---
 rtl/stream_aux_slave.sv | 134 +++++++++++++
 tb/tb_stream_aux_slave.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_aux_slave.sv
// AXI-Stream sink that checks an incrementing 1..N payload and tlast position
// under a programmable periodic backpressure pattern.
module stream_aux_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    input  logic                  tlast,
    output logic                  tready,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] total_num,
    input  logic [7:0]            stall_period,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  beat_count,
    output logic [ERR_WIDTH-1:0]  data_err_count,
    output logic [ERR_WIDTH-1:0]  last_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_total;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [7:0]            r_period;
    logic [7:0]            r_stall;
    logic [ERR_WIDTH-1:0]  r_beat;
    logic [ERR_WIDTH-1:0]  r_derr;
    logic [ERR_WIDTH-1:0]  r_lerr;
    logic                  r_passed;

    logic w_stall;
    logic w_hs;
    logic w_last_hit;
    logic w_last_err;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : (v + ERR_WIDTH'(1));
    endfunction

    assign w_stall    = (r_period >= 8'd2) && (r_stall == (r_period - 8'd1));
    assign w_hs       = tvalid && tready;
    assign w_last_hit = (r_expected == r_total);
    // Once the expected final beat went by without tlast, every later beat is misplaced.
    assign w_last_err = r_passed || (tlast != w_last_hit);

    assign tready         = (r_state == ST_RECV) && !w_stall;
    assign busy           = (r_state == ST_RECV);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_derr == {ERR_WIDTH{1'b0}}) && (r_lerr == {ERR_WIDTH{1'b0}});
    assign beat_count     = r_beat;
    assign data_err_count = r_derr;
    assign last_err_count = r_lerr;

    // Transfer FSM, stall counter and beat checking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_total    <= {DATA_WIDTH{1'b0}};
            r_expected <= DATA_WIDTH'(1);
            r_period   <= 8'd0;
            r_stall    <= 8'd0;
            r_beat     <= {ERR_WIDTH{1'b0}};
            r_derr     <= {ERR_WIDTH{1'b0}};
            r_lerr     <= {ERR_WIDTH{1'b0}};
            r_passed   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RECV;
                        r_total    <= total_num;
                        r_period   <= stall_period;
                        r_expected <= DATA_WIDTH'(1);
                        r_stall    <= 8'd0;
                        r_beat     <= {ERR_WIDTH{1'b0}};
                        r_derr     <= {ERR_WIDTH{1'b0}};
                        r_lerr     <= {ERR_WIDTH{1'b0}};
                        r_passed   <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_RECV: begin
                    if (r_period < 8'd2) begin
                        r_stall <= 8'd0;
                    end else if (w_stall) begin
                        r_stall <= 8'd0;
                    end else begin
                        r_stall <= r_stall + 8'd1;
                    end
                    if (w_hs) begin
                        r_beat     <= sat_inc(r_beat);
                        r_expected <= r_expected + DATA_WIDTH'(1);
                        if (tdata != r_expected) begin
                            r_derr <= sat_inc(r_derr);
                        end else begin
                            r_derr <= r_derr;
                        end
                        if (w_last_err) begin
                            r_lerr <= sat_inc(r_lerr);
                        end else begin
                            r_lerr <= r_lerr;
                        end
                        if (w_last_hit && !tlast) begin
                            r_passed <= 1'b1;
                        end else begin
                            r_passed <= r_passed;
                        end
                        if (tlast) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RECV;
                        end
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_aux_slave.sv
// Randomized scoreboard bench for stream_aux_slave (8-bit data, 4-bit counters).
module tb_stream_aux_slave;

    localparam int DW = 8;
    localparam int EW = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          start;
    logic [DW-1:0] total_num;
    logic [7:0]    stall_period;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] beat_count;
    logic [EW-1:0] data_err_count;
    logic [EW-1:0] last_err_count;

    stream_aux_slave #(.DATA_WIDTH(DW), .ERR_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
        .tready(tready), .start(start), .total_num(total_num),
        .stall_period(stall_period), .busy(busy), .done(done), .pass(pass),
        .beat_count(beat_count), .data_err_count(data_err_count),
        .last_err_count(last_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bc;
        int de;
        int le;
        int ps;
    } exp_t;

    exp_t sbq[$];
    int   tx_data[$];
    bit   tx_last[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_period = 0;
    int   max_gap = 0;
    bit   timed_out = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: beat i carries i mod 256; tlast belongs on the first beat k with k mod 256 == total.
    function automatic exp_t model(input int total);
        exp_t e;
        int   k;
        k = (total == 0) ? 256 : total;
        e.bc = 0; e.de = 0; e.le = 0;
        for (int i = 1; i <= tx_data.size(); i++) begin
            e.bc++;
            if (tx_data[i-1] != (i % 256)) e.de++;
            if ((i > k) || ((i == k) != tx_last[i-1])) e.le++;
        end
        e.ps = (e.de == 0 && e.le == 0) ? 1 : 0;
        if (e.bc > SAT) e.bc = SAT;
        if (e.de > SAT) e.de = SAT;
        if (e.le > SAT) e.le = SAT;
        return e;
    endfunction

    task automatic build(input int n, input int last_at);
        tx_data.delete();
        tx_last.delete();
        for (int i = 1; i <= n; i++) begin
            tx_data.push_back(i % 256);
            tx_last.push_back(i == last_at);
        end
    endtask

    task automatic do_start(input int total, input int period);
        @(posedge clk); #1;
        start = 1'b1; total_num = DW'(total); stall_period = 8'(period); cur_period = period;
        @(posedge clk); #1;
        start = 1'b0; total_num = DW'($urandom); stall_period = 8'($urandom);
    endtask

    // Sends tx_* beats; aborts with rst after abort_after handshakes; pulses start on beat start_mid.
    task automatic send(input int abort_after, input int start_mid);
        int  acc;
        int  t;
        bit  hs;
        acc = 0;
        for (int i = 0; i < tx_data.size(); i++) begin
            tvalid = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            tvalid = 1'b1; tdata = DW'(tx_data[i]); tlast = tx_last[i];
            if (i == start_mid) begin
                start = 1'b1; total_num = 8'hAB; stall_period = 8'd2;
            end
            hs = 1'b0; t = 0;
            while (!hs && !timed_out) begin
                @(negedge clk); hs = tready;
                @(posedge clk); #1;
                start = 1'b0;
                t++;
                if (!hs && t > 50) begin
                    timed_out = 1'b1;
                    chk("beat_timeout", 32'(t), 32'd0);
                end
            end
            if (timed_out) return;
            acc++;
            if (acc == abort_after) begin
                tvalid = 1'b0; tlast = 1'b0; rst = 1'b1; #1;
                chk("rst_tready", tready, 0);  chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);      chk("rst_pass", pass, 0);
                chk("rst_beats", beat_count, 0);
                chk("rst_derr", data_err_count, 0);
                chk("rst_lerr", last_err_count, 0);
                @(posedge clk); #1; rst = 1'b0;
                return;
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic run(input int total, input int period, input int start_mid);
        do_start(total, period);
        sbq.push_back(model(total));
        send(-1, start_mid);
    endtask

    // Monitor: backpressure pattern, end-of-transfer latency, scoreboard pop on done.
    bit prev_done = 1'b0;
    bit prev_hs_last = 1'b0;
    int rc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rc = 0; prev_done = 1'b0; prev_hs_last = 1'b0;
        end else begin
            if (busy) begin
                rc++;
                chk("tready_pattern", tready, (cur_period >= 2 && rc % cur_period == 0) ? 0 : 1);
            end else begin
                rc = 0;
                chk("tready_idle", tready, 0);
            end
            if (prev_hs_last) begin
                chk("done_latency", done, 1);
                chk("busy_end", busy, 0);
            end
            if (done && !prev_done) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("beat_count", beat_count, e.bc);
                    chk("data_err", data_err_count, e.de);
                    chk("last_err", last_err_count, e.le);
                    chk("pass", pass, e.ps);
                end
            end
            prev_done = done;
            prev_hs_last = busy && tvalid && tready && tlast;
        end
    end

    initial begin
        int total;
        int len;
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tlast = 1'b0;
        tdata = '0; total_num = '0; stall_period = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset_tready", tready, 0); chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);     chk("reset_pass", pass, 0);
        chk("reset_beats", beat_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        max_gap = 0;
        build(4, 4);                         run(4, 0, -1);   // clean
        build(6, 6);                         run(6, 3, -1);   // backpressure
        build(4, 4); tx_data[2] = 7;         run(4, 0, -1);   // bad data
        build(2, 2);                         run(4, 1, -1);   // early last
        build(5, 5);                         run(3, 2, -1);   // late last
        build(5, 5); do_start(5, 0); send(2, -1);             // reset mid-transfer
        chk("post_rst_busy", busy, 0);
        build(2, 2);                         run(2, 0, 1);    // restart, start mid-RECV ignored
        build(20, 20);
        for (int i = 0; i < 20; i++) tx_data[i] = (i + 101) % 256;
        run(20, 0, -1);                                       // error saturation
        build(256, 256);                     run(0, 0, -1);   // expected wraps to 0

        max_gap = 2;
        for (int n = 0; n < 10 && !timed_out; n++) begin
            total = $urandom_range(1, 10);
            len   = $urandom_range(1, 12);
            build(len, len);
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 9) == 0) tx_data[i] = $urandom_range(0, 255);
            run(total, $urandom_range(0, 4), -1);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
